// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one bit pair per clock, LSB first, through one full-adder cell.
// Optional signed-overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         a_ns,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sr;
    logic          c;
    logic [CW-1:0] cnt;

    logic          s;
    logic          c_next;
    logic [N-1:0]  sr_next;

    // The single add/sub cell: subtraction arrives here as a + ~b with carry-in 1.
    assign s       = sa[0] ^ sb[0] ^ c;
    assign c_next  = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign sr_next = N'({s, sr} >> 1);

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments here would let the
    // carry and shift registers see each other's new values mid-block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= a_ns ? b : ~b;
                        c     <= ~a_ns;
                        sr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_next;
                    sr  <= sr_next;
                    cnt <= cnt + CW'(1);
                    // Publish result and flags together so they are never seen half-updated.
                    if (cnt == LAST) begin
                        result <= sr_next;
                        cout   <= c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf    <= c ^ c_next;
`endif
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (N=8): add, subtract, wrap,
// ignored start while busy, back-to-back operation and mid-run reset.
module tb_serial_addsub;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         a_ns = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_addsub #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_ns   (a_ns),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from an idle/done state; operands are scrambled right after the start edge.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tns, input logic [N-1:0] er, input logic ec, input logic eo);
        int busy_cycles;
        int early_done;
        busy_cycles = 0;
        early_done  = 0;
        a = ta; b = tb; a_ns = tns; start = 1'b1;
        tick();
        start = 1'b0; a = ~ta; b = ~tb; a_ns = ~tns;
        for (int i = 0; i < N; i++) begin
            if (busy) busy_cycles++;
            if (done) early_done++;
            tick();
        end
        check({tag, " busy_cycles"}, busy_cycles, N);
        check({tag, " early_done"}, early_done, 0);
        check({tag, " done"}, done, 1);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, " ovf"}, ovf, eo);
`else
        if (eo !== eo) $display("unreachable");
`endif
        tick();
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " result_held"}, result, er);
    endtask

    initial begin
        int dones;
        int k;
        int last;
        logic [N-1:0] bb_a [3];
        logic [N-1:0] bb_b [3];
        logic         bb_ns[3];
        logic [N-1:0] bb_r [3];
        logic         bb_c [3];

        // Reset state
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst cout", cout, 0);
        rst = 1'b0;
        tick();

        do_op("add_3c_05", 8'h3C, 8'h05, 1'b1, 8'h41, 1'b0, 1'b0);
        do_op("sub_3c_05", 8'h3C, 8'h05, 1'b0, 8'h37, 1'b1, 1'b0);
        do_op("sub_05_3c", 8'h05, 8'h3C, 1'b0, 8'hC9, 1'b0, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        do_op("sub_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // start pulses during RUN with different operands must be ignored
        a = 8'h3C; b = 8'h05; a_ns = 1'b1; start = 1'b1;
        tick();
        dones = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 3 || i == 5) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; a_ns = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            tick();
        end
        start = 1'b0;
        check("ign done", done, 1);
        check("ign result", result, 8'h41);
        check("ign cout", cout, 0);
        for (int i = 0; i < N + 3; i++) begin
            if (done) dones++;
            tick();
        end
        check("ign done_count", dones, 1);
        check("ign idle_busy", busy, 0);

        // Back-to-back: start held high, expect a completion every N+1 cycles
        bb_a[0] = 8'h10; bb_b[0] = 8'h20; bb_ns[0] = 1'b1; bb_r[0] = 8'h30; bb_c[0] = 1'b0;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_ns[1] = 1'b1; bb_r[1] = 8'h00; bb_c[1] = 1'b1;
        bb_a[2] = 8'h01; bb_b[2] = 8'h02; bb_ns[2] = 1'b0; bb_r[2] = 8'hFF; bb_c[2] = 1'b0;
        k = 0;
        last = 0;
        a = bb_a[0]; b = bb_b[0]; a_ns = bb_ns[0]; start = 1'b1;
        for (int cyc = 0; cyc < 3 * (N + 1) + 4; cyc++) begin
            tick();
            if (done) begin
                if (k < 3) begin
                    check($sformatf("b2b%0d result", k), result, bb_r[k]);
                    check($sformatf("b2b%0d cout", k), cout, bb_c[k]);
                    if (k > 0) check($sformatf("b2b%0d period", k), cyc - last, N + 1);
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    a = bb_a[k]; b = bb_b[k]; a_ns = bb_ns[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b count", k, 3);
        tick();
        tick();

        // Reset at RUN cycle 4: abort with no done pulse
        a = 8'h12; b = 8'h34; a_ns = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst busy", busy, 0);
        check("mid_rst done", done, 0);
        check("mid_rst result", result, 0);
        check("mid_rst cout", cout, 0);
        dones = 0;
        for (int i = 0; i < N + 2; i++) begin
            if (done || busy) dones++;
            tick();
        end
        check("mid_rst no_activity", dones, 0);
        do_op("after_rst", 8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
